// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I control-flow definitions.
// Holds the opcode and funct3 constants, the branch-resolve state enum and
// the immediate decoders used by the branch resolution logic.
package rv_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESOLVE  = 2'd1,
        REDIRECT = 2'd2
    } br_state_t;

    // Sign-extended B-type immediate (byte offset, bit 0 always 0).
    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    // Sign-extended J-type immediate (byte offset, bit 0 always 0).
    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // Sign-extended I-type immediate.
    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational conditional-branch comparator.
// Ports:
//   funct3  in  3     branch condition select
//   op_a    in  XLEN  rs1 operand
//   op_b    in  XLEN  rs2 operand
//   taken   out 1     condition true; funct3 010/011 (not branches) give 0
module branch_cmp
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (op_a == op_b);
            F3_BNE:  taken = (op_a != op_b);
            F3_BLT:  taken = ($signed(op_a) <  $signed(op_b));
            F3_BGE:  taken = ($signed(op_a) >= $signed(op_b));
            F3_BLTU: taken = (op_a <  op_b);
            F3_BGEU: taken = (op_a >= op_b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolution side of the PC redirect interface.
// Detects JAL/JALR/BRANCH in the fetched instruction, holds it for one
// RESOLVE cycle (the PC's STALL cycle) where b_taken/up_amt are presented,
// then raises flush for one REDIRECT cycle (the PC's JUMP cycle) when the
// PC will jump. Also drives the link-register write and branch counters.
// Ports:
//   CLK, RESET_N          clock, async active-low reset
//   INSTR, IP             fetched instruction and its PC
//   RS1_DATA, RS2_DATA    regfile read data for RS1_ADDR/RS2_ADDR
//   RS1_ADDR, RS2_ADDR    regfile read addresses (held instr in RESOLVE)
//   OP                    opcode to the PC (held opcode in RESOLVE)
//   b_taken, up_amt       branch decision and target offset (RESOLVE only)
//   link_we/rd/val        link write for JAL/JALR
//   flush                 squash fetched instruction (REDIRECT)
//   n_branch, n_taken     conditional-branch perf counters
//   dbg_state             current FSM state, for observation
module branch_resolve
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [XLEN-1:0]  INSTR,
    input  logic [XLEN-1:0]  IP,
    input  logic [XLEN-1:0]  RS1_DATA,
    input  logic [XLEN-1:0]  RS2_DATA,
    output logic [4:0]       RS1_ADDR,
    output logic [4:0]       RS2_ADDR,
    output logic [6:0]       OP,
    output logic             b_taken,
    output logic [XLEN-1:0]  up_amt,
    output logic             link_we,
    output logic [4:0]       link_rd,
    output logic [XLEN-1:0]  link_val,
    output logic             flush,
    output logic [CNT_W-1:0] n_branch,
    output logic [CNT_W-1:0] n_taken,
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    br_state_t       state_q, state_d;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] ip_q;
    logic [CNT_W-1:0] n_branch_q, n_taken_q;

    logic            in_resolve;
    logic            is_ctrl;
    logic            capture;
    logic [XLEN-1:0] act_instr;
    logic [6:0]      hold_op;
    logic            cmp_taken;
    logic            br_inc;
    logic            tk_inc;
    logic [XLEN-1:0] jalr_tgt;

    assign in_resolve = (state_q == RESOLVE);
    assign is_ctrl    = (INSTR[6:0] == OPC_JAL) || (INSTR[6:0] == OPC_JALR) ||
                        (INSTR[6:0] == OPC_BRANCH);
    assign capture    = (state_q == IDLE) && is_ctrl;

    // During RESOLVE the regfile must be addressed by the held instruction,
    // since fetch has already moved on.
    assign act_instr = in_resolve ? instr_q : INSTR;
    assign RS1_ADDR  = act_instr[19:15];
    assign RS2_ADDR  = act_instr[24:20];
    assign OP        = act_instr[6:0];
    assign hold_op   = instr_q[6:0];

    // Bit 0 of a JALR target is cleared before the offset is formed.
    assign jalr_tgt = (RS1_DATA + imm_i(instr_q)) & ~32'd1;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3 (instr_q[14:12]),
        .op_a   (RS1_DATA),
        .op_b   (RS2_DATA),
        .taken  (cmp_taken)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            ip_q       <= '0;
            n_branch_q <= '0;
            n_taken_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                instr_q <= INSTR;
                ip_q    <= IP;
            end
            if (br_inc) n_branch_q <= n_branch_q + CNT_ONE;
            if (tk_inc) n_taken_q  <= n_taken_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d  = state_q;
        b_taken  = 1'b0;
        up_amt   = '0;
        link_we  = 1'b0;
        link_rd  = '0;
        link_val = '0;
        flush    = 1'b0;
        br_inc   = 1'b0;
        tk_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_ctrl) state_d = RESOLVE;
            end
            RESOLVE: begin
                state_d = IDLE;
                case (hold_op)
                    OPC_BRANCH: begin
                        b_taken = cmp_taken;
                        up_amt  = imm_b(instr_q);
                        br_inc  = 1'b1;
                        tk_inc  = cmp_taken;
                        if (cmp_taken) state_d = REDIRECT;
                    end
                    OPC_JAL, OPC_JALR: begin
                        up_amt   = (hold_op == OPC_JAL) ? imm_j(instr_q) : (jalr_tgt - ip_q);
                        link_we  = (instr_q[11:7] != 5'd0);
                        link_rd  = instr_q[11:7];
                        link_val = ip_q + 32'd4;
                        state_d  = REDIRECT;
                    end
                    default: state_d = IDLE;
                endcase
            end
            REDIRECT: begin
                flush   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign n_branch  = n_branch_q;
    assign n_taken   = n_taken_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] INSTR, IP, RS1_DATA, RS2_DATA;
    logic [4:0]  RS1_ADDR, RS2_ADDR, link_rd;
    logic [6:0]  OP;
    logic        b_taken, link_we, flush;
    logic [31:0] up_amt, link_val, n_branch, n_taken;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    branch_resolve #(.XLEN(32), .CNT_W(32)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .INSTR(INSTR), .IP(IP),
        .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
        .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .OP(OP),
        .b_taken(b_taken), .up_amt(up_amt),
        .link_we(link_we), .link_rd(link_rd), .link_val(link_val),
        .flush(flush), .n_branch(n_branch), .n_taken(n_taken),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    // driver: present a control op in IDLE, land in RESOLVE with fetch on NOP
    task automatic present(input logic [31:0] instr, input logic [31:0] ip,
                           input logic [31:0] rs1, input logic [31:0] rs2);
        @(posedge CLK); #1;
        INSTR = instr; IP = ip; RS1_DATA = rs1; RS2_DATA = rs2;
        @(posedge CLK); #1;
        INSTR = NOP;
        #1;
    endtask

    task automatic step();
        @(posedge CLK); #2;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; INSTR = 32'h0020_81B3; IP = 32'h123;
        RS1_DATA = 32'h0; RS2_DATA = 32'h0;
        #12;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        checks++; if (b_taken !== 1'b0) begin errors++; $display("FAIL reset_b_taken got %b exp 0", b_taken); end
        checks++; if (up_amt !== 32'h0) begin errors++; $display("FAIL reset_up_amt got %h exp 0", up_amt); end
        checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL reset_link_we got %b exp 0", link_we); end
        checks++; if (link_val !== 32'h0) begin errors++; $display("FAIL reset_link_val got %h exp 0", link_val); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
        checks++; if (n_branch !== 32'h0) begin errors++; $display("FAIL reset_n_branch got %0d exp 0", n_branch); end
        checks++; if (OP !== 7'h33) begin errors++; $display("FAIL reset_op got %h exp 33", OP); end
        checks++; if (RS1_ADDR !== 5'd1) begin errors++; $display("FAIL reset_rs1 got %0d exp 1", RS1_ADDR); end
        checks++; if (RS2_ADDR !== 5'd2) begin errors++; $display("FAIL reset_rs2 got %0d exp 2", RS2_ADDR); end
        INSTR = NOP;
        @(negedge CLK); RESET_N = 1'b1;
    endtask

    task automatic test_beq();
        present(32'h0020_8863, 32'h100, 32'd5, 32'd5);
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL beq_state got %0d exp 1", dbg_state); end
        checks++; if (b_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %b exp 1", b_taken); end
        checks++; if (up_amt !== 32'h10) begin errors++; $display("FAIL beq_up_amt got %h exp 10", up_amt); end
        checks++; if (OP !== 7'h63) begin errors++; $display("FAIL beq_op got %h exp 63", OP); end
        checks++; if (RS1_ADDR !== 5'd1) begin errors++; $display("FAIL beq_rs1 got %0d exp 1", RS1_ADDR); end
        checks++; if (RS2_ADDR !== 5'd2) begin errors++; $display("FAIL beq_rs2 got %0d exp 2", RS2_ADDR); end
        checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL beq_link_we got %b exp 0", link_we); end
        step();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush got %b exp 1", flush); end
        checks++; if (b_taken !== 1'b0) begin errors++; $display("FAIL beq_taken_redir got %b exp 0", b_taken); end
        checks++; if (up_amt !== 32'h0) begin errors++; $display("FAIL beq_up_redir got %h exp 0", up_amt); end
        checks++; if (n_branch !== 32'd1) begin errors++; $display("FAIL beq_n_branch got %0d exp 1", n_branch); end
        checks++; if (n_taken !== 32'd1) begin errors++; $display("FAIL beq_n_taken got %0d exp 1", n_taken); end
        step();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL beq_flush_end got %b exp 0", flush); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL beq_idle got %0d exp 0", dbg_state); end
    endtask

    task automatic test_blt_bltu();
        present(32'hFE41_CCE3, 32'h40, 32'hFFFF_FFFF, 32'd1);
        checks++; if (b_taken !== 1'b1) begin errors++; $display("FAIL blt_taken got %b exp 1", b_taken); end
        checks++; if (up_amt !== 32'hFFFF_FFF8) begin errors++; $display("FAIL blt_up_amt got %h exp fffffff8", up_amt); end
        checks++; if (RS1_ADDR !== 5'd3) begin errors++; $display("FAIL blt_rs1 got %0d exp 3", RS1_ADDR); end
        step();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL blt_flush got %b exp 1", flush); end
        step();
        present(32'hFE41_ECE3, 32'h40, 32'hFFFF_FFFF, 32'd1);
        checks++; if (b_taken !== 1'b0) begin errors++; $display("FAIL bltu_taken got %b exp 0", b_taken); end
        checks++; if (up_amt !== 32'hFFFF_FFF8) begin errors++; $display("FAIL bltu_up_amt got %h exp fffffff8", up_amt); end
        step();
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL bltu_flush got %b exp 0", flush); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL bltu_state got %0d exp 0", dbg_state); end
        checks++; if (n_branch !== 32'd3) begin errors++; $display("FAIL bltu_n_branch got %0d exp 3", n_branch); end
        checks++; if (n_taken !== 32'd2) begin errors++; $display("FAIL bltu_n_taken got %0d exp 2", n_taken); end
    endtask

    task automatic test_branch_table();
        logic [31:0] t_instr [5];
        logic [31:0] t_rs1 [5];
        logic [31:0] t_rs2 [5];
        logic        t_exp [5];
        t_instr[0] = 32'h0020_9863; t_rs1[0] = 32'd5;         t_rs2[0] = 32'd5; t_exp[0] = 1'b0; // BNE equal
        t_instr[1] = 32'h0020_D863; t_rs1[1] = 32'h8000_0000; t_rs2[1] = 32'd1; t_exp[1] = 1'b0; // BGE neg>=1
        t_instr[2] = 32'h0020_F863; t_rs1[2] = 32'h8000_0000; t_rs2[2] = 32'd1; t_exp[2] = 1'b1; // BGEU
        t_instr[3] = 32'h0020_A863; t_rs1[3] = 32'd0;         t_rs2[3] = 32'd1; t_exp[3] = 1'b0; // funct3 010
        t_instr[4] = 32'h0020_8863; t_rs1[4] = 32'd7;         t_rs2[4] = 32'd8; t_exp[4] = 1'b0; // BEQ unequal
        for (int k = 0; k < 5; k++) begin
            present(t_instr[k], 32'h500, t_rs1[k], t_rs2[k]);
            checks++; if (b_taken !== t_exp[k]) begin errors++; $display("FAIL tbl%0d_taken got %b exp %b", k, b_taken, t_exp[k]); end
            checks++; if (up_amt !== 32'h10) begin errors++; $display("FAIL tbl%0d_up_amt got %h exp 10", k, up_amt); end
            step();
            checks++; if (flush !== t_exp[k]) begin errors++; $display("FAIL tbl%0d_flush got %b exp %b", k, flush, t_exp[k]); end
            step();
        end
        checks++; if (n_branch !== 32'd8) begin errors++; $display("FAIL tbl_n_branch got %0d exp 8", n_branch); end
        checks++; if (n_taken !== 32'd3) begin errors++; $display("FAIL tbl_n_taken got %0d exp 3", n_taken); end
    endtask

    task automatic test_jal();
        present(32'h0010_00EF, 32'h200, 32'h0, 32'h0);
        checks++; if (up_amt !== 32'h800) begin errors++; $display("FAIL jal_up_amt got %h exp 800", up_amt); end
        checks++; if (link_we !== 1'b1) begin errors++; $display("FAIL jal_link_we got %b exp 1", link_we); end
        checks++; if (link_rd !== 5'd1) begin errors++; $display("FAIL jal_link_rd got %0d exp 1", link_rd); end
        checks++; if (link_val !== 32'h204) begin errors++; $display("FAIL jal_link_val got %h exp 204", link_val); end
        checks++; if (b_taken !== 1'b0) begin errors++; $display("FAIL jal_taken got %b exp 0", b_taken); end
        checks++; if (OP !== 7'h6F) begin errors++; $display("FAIL jal_op got %h exp 6f", OP); end
        step();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jal_flush got %b exp 1", flush); end
        checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL jal_link_we_pulse got %b exp 0", link_we); end
        step();
        present(32'h0010_006F, 32'h200, 32'h0, 32'h0);
        checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL jal_x0_link_we got %b exp 0", link_we); end
        checks++; if (up_amt !== 32'h800) begin errors++; $display("FAIL jal_x0_up_amt got %h exp 800", up_amt); end
        step();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jal_x0_flush got %b exp 1", flush); end
        step();
        present(32'h0010_00EF, 32'hFFFF_FFFC, 32'h0, 32'h0);
        checks++; if (link_val !== 32'h0) begin errors++; $display("FAIL jal_wrap_link_val got %h exp 0", link_val); end
        step();
        step();
        checks++; if (n_branch !== 32'd8) begin errors++; $display("FAIL jal_n_branch got %0d exp 8", n_branch); end
    endtask

    task automatic test_jalr();
        present(32'h00C2_80E7, 32'h300, 32'h1001, 32'h0);
        checks++; if (RS1_ADDR !== 5'd5) begin errors++; $display("FAIL jalr_rs1 got %0d exp 5", RS1_ADDR); end
        checks++; if (up_amt !== 32'hD0C) begin errors++; $display("FAIL jalr_up_amt got %h exp d0c", up_amt); end
        checks++; if (link_we !== 1'b1) begin errors++; $display("FAIL jalr_link_we got %b exp 1", link_we); end
        checks++; if (link_val !== 32'h304) begin errors++; $display("FAIL jalr_link_val got %h exp 304", link_val); end
        checks++; if (b_taken !== 1'b0) begin errors++; $display("FAIL jalr_taken got %b exp 0", b_taken); end
        step();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jalr_flush got %b exp 1", flush); end
        step();
    endtask

    task automatic test_back_to_back();
        present(32'h0010_00EF, 32'h200, 32'h0, 32'h0);
        step();
        // REDIRECT: a branch shows up here and must not be captured yet
        INSTR = 32'h0020_8863; IP = 32'h208; RS1_DATA = 32'd5; RS2_DATA = 32'd5;
        step();
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL b2b_ignore got %0d exp 0", dbg_state); end
        step();
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL b2b_capture got %0d exp 1", dbg_state); end
        checks++; if (b_taken !== 1'b1) begin errors++; $display("FAIL b2b_taken got %b exp 1", b_taken); end
        checks++; if (up_amt !== 32'h10) begin errors++; $display("FAIL b2b_up_amt got %h exp 10", up_amt); end
        INSTR = NOP;
        step();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush got %b exp 1", flush); end
        checks++; if (n_branch !== 32'd9) begin errors++; $display("FAIL b2b_n_branch got %0d exp 9", n_branch); end
        checks++; if (n_taken !== 32'd4) begin errors++; $display("FAIL b2b_n_taken got %0d exp 4", n_taken); end
        step();
    endtask

    task automatic test_non_control();
        INSTR = 32'h0020_81B3;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL nc%0d_state got %0d exp 0", k, dbg_state); end
            checks++; if ({b_taken, link_we, flush} !== 3'b000) begin errors++; $display("FAIL nc%0d_ctl got %b exp 000", k, {b_taken, link_we, flush}); end
            checks++; if (up_amt !== 32'h0) begin errors++; $display("FAIL nc%0d_up_amt got %h exp 0", k, up_amt); end
            checks++; if ({link_rd, link_val} !== 37'h0) begin errors++; $display("FAIL nc%0d_link got %h exp 0", k, {link_rd, link_val}); end
            checks++; if ({OP, RS1_ADDR, RS2_ADDR} !== {7'h33, 5'd1, 5'd2}) begin errors++; $display("FAIL nc%0d_fields got %h exp %h", k, {OP, RS1_ADDR, RS2_ADDR}, {7'h33, 5'd1, 5'd2}); end
        end
        INSTR = NOP;
    endtask

    task automatic test_reset_mid();
        present(32'h0010_00EF, 32'h200, 32'h0, 32'h0);
        checks++; if (link_we !== 1'b1) begin errors++; $display("FAIL rstm_pre_link_we got %b exp 1", link_we); end
        RESET_N = 1'b0;
        #1;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rstm_state got %0d exp 0", dbg_state); end
        checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL rstm_link_we got %b exp 0", link_we); end
        checks++; if (b_taken !== 1'b0) begin errors++; $display("FAIL rstm_taken got %b exp 0", b_taken); end
        checks++; if (up_amt !== 32'h0) begin errors++; $display("FAIL rstm_up_amt got %h exp 0", up_amt); end
        checks++; if (n_branch !== 32'h0) begin errors++; $display("FAIL rstm_n_branch got %0d exp 0", n_branch); end
        step();
        checks++; if ({flush, link_we} !== 2'b00) begin errors++; $display("FAIL rstm_edge got %b exp 00", {flush, link_we}); end
        RESET_N = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if ({flush, link_we} !== 2'b00) begin errors++; $display("FAIL rstm_after%0d got %b exp 00", k, {flush, link_we}); end
            checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rstm_after%0d_state got %0d exp 0", k, dbg_state); end
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_blt_bltu();
        test_branch_table();
        test_jal();
        test_jalr();
        test_back_to_back();
        test_non_control();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
